aq_jpeg_hm_bitpack: RTL and testbench

Huffman bitstream packer for the JPEG encode path; it is the transmitter-side counterpart of the decoder's 32-bit DataIn / DecodeUseWidth bit-consumer interface.
- Accepts variable-length codes of 0..32 bits, MSB-first, and packs them into a byte stream.
- Inserts JPEG 0xFF→0xFF 0x00 byte stuffing.
- On flush, pads the final partial byte with 1s.
- Sits between the Huffman/VLC code generator and the marker/byte-output stage.

---
 rtl/aq_jpeg_pkg.sv | 21 ++
 rtl/aq_jpeg_bitmask.sv | 20 ++
 rtl/aq_jpeg_hm_bitpack.sv | 173 +++++++++++++++++
 tb/tb_aq_jpeg_hm_bitpack.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aq_jpeg_pkg.sv
// Shared definitions for the JPEG Huffman bitstream packer and its VLC neighbours.
// Revision: 1.0
`default_nettype none

package aq_jpeg_pkg;

    localparam int ACC_W = 64;
    localparam logic [7:0] JPEG_STUFF_BYTE = 8'hFF;
    localparam logic JPEG_PAD_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_STUFF = 3'd1,
        ST_FLUSH = 3'd2,
        ST_PAD   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/aq_jpeg_bitmask.sv
// Width-to-mask generator: returns the low `width_i` bits set, saturating at 32.
// Revision: 1.0
`default_nettype none

module aq_jpeg_bitmask (
    input  logic [5:0]  width_i,
    output logic [31:0] mask_o
);

    always_comb begin
        if (width_i >= 6'd32) begin
            mask_o = '1;
        end else begin
            mask_o = (32'd1 << width_i) - 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aq_jpeg_hm_bitpack.sv
// Packs MSB-first variable-length codes into a JPEG byte stream with 0xFF stuffing and 1-padding on flush.
// Revision: 1.0
`default_nettype none

module aq_jpeg_hm_bitpack
    import aq_jpeg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ProcessInit,
    input  logic        CodeInEnable,
    output logic        CodeInReady,
    input  logic [31:0] CodeInData,
    input  logic [5:0]  CodeInWidth,
    input  logic        FlushReq,
    output logic        FlushDone,
    output logic        DataOutEnable,
    output logic [7:0]  DataOutData,
    input  logic        DataOutRead,
    output logic        Busy
);

    localparam logic [6:0] ACC_POS = 7'(ACC_W);
    localparam logic [ACC_W-1:0] PAD_MASK = {{8{JPEG_PAD_BIT}}, {(ACC_W-8){1'b0}}};

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_s;
    logic [6:0]         cnt_q, cnt_d, cnt_s;
    logic               pend_q, pend_d;
    logic               stuffdone_q, stuffdone_d;
    logic               fdone_q, fdone_d;
    logic               den_q, den_d;
    logic [7:0]         dout_q, dout_d;

    logic [5:0]         width;
    logic [31:0]        mask;
    logic [ACC_W-1:0]   code;
    logic               slot_free;
    logic               accept;

    assign width = (CodeInWidth > 6'd32) ? 6'd32 : CodeInWidth;

    aq_jpeg_bitmask u_mask (
        .width_i (width),
        .mask_o  (mask)
    );

    assign code        = {32'd0, CodeInData & mask};
    assign slot_free   = !den_q || DataOutRead;
    assign CodeInReady = (state_q == ST_RUN) && (cnt_q <= 7'd32) && !pend_q;
    assign accept      = CodeInEnable && CodeInReady;

    assign FlushDone     = fdone_q;
    assign DataOutEnable = den_q;
    assign DataOutData   = dout_q;
    assign Busy          = (cnt_q != 7'd0) || den_q || (state_q == ST_STUFF)
                           || (state_q == ST_FLUSH) || (state_q == ST_PAD);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_s       = acc_q;
        cnt_s       = cnt_q;
        pend_d      = pend_q || FlushReq;
        stuffdone_d = stuffdone_q;
        fdone_d     = 1'b0;
        dout_d      = dout_q;
        den_d       = den_q && !DataOutRead;

        case (state_q)
            ST_RUN: begin
                if (slot_free && cnt_q >= 7'd8) begin
                    dout_d = acc_q[ACC_W-1 -: 8];
                    den_d  = 1'b1;
                    acc_s  = acc_q << 8;
                    cnt_s  = cnt_q - 7'd8;
                    if (acc_q[ACC_W-1 -: 8] == JPEG_STUFF_BYTE) begin
                        state_d     = ST_STUFF;
                        stuffdone_d = 1'b0;
                    end
                end
                // Append lands just below the bits that remain after this cycle's extraction.
                if (accept) begin
                    acc_s = acc_s | (code << (ACC_POS - cnt_s - {1'b0, width}));
                    cnt_s = cnt_s + {1'b0, width};
                end
                acc_d = acc_s;
                cnt_d = cnt_s;
                if (pend_q && cnt_q < 7'd8) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_STUFF: begin
                if (slot_free) begin
                    dout_d  = 8'h00;
                    den_d   = 1'b1;
                    state_d = stuffdone_q ? ST_DONE : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 7'd0) begin
                    state_d = ST_DONE;
                end else begin
                    acc_d   = acc_q | ((PAD_MASK >> cnt_q) & PAD_MASK);
                    cnt_d   = 7'd8;
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (slot_free) begin
                    dout_d = acc_q[ACC_W-1 -: 8];
                    den_d  = 1'b1;
                    acc_d  = acc_q << 8;
                    cnt_d  = 7'd0;
                    if (acc_q[ACC_W-1 -: 8] == JPEG_STUFF_BYTE) begin
                        state_d     = ST_STUFF;
                        stuffdone_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A FlushReq landing on the completion cycle belongs to the finished flush.
                if (slot_free) begin
                    fdone_d = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (ProcessInit) begin
            state_d     = ST_RUN;
            acc_d       = '0;
            cnt_d       = 7'd0;
            pend_d      = 1'b0;
            stuffdone_d = 1'b0;
            fdone_d     = 1'b0;
            dout_d      = 8'h00;
            den_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            acc_q       <= '0;
            cnt_q       <= 7'd0;
            pend_q      <= 1'b0;
            stuffdone_q <= 1'b0;
            fdone_q     <= 1'b0;
            dout_q      <= 8'h00;
            den_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            stuffdone_q <= stuffdone_d;
            fdone_q     <= fdone_d;
            dout_q      <= dout_d;
            den_q       <= den_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aq_jpeg_hm_bitpack.sv
// Directed self-checking bench for aq_jpeg_hm_bitpack.
// Revision: 1.0
`default_nettype none

module tb_aq_jpeg_hm_bitpack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ProcessInit = 1'b0;
    logic        CodeInEnable = 1'b0;
    logic        CodeInReady;
    logic [31:0] CodeInData = '0;
    logic [5:0]  CodeInWidth = '0;
    logic        FlushReq = 1'b0;
    logic        FlushDone;
    logic        DataOutEnable;
    logic [7:0]  DataOutData;
    logic        DataOutRead = 1'b0;
    logic        Busy;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fd_n = 0;
    int          fd_cyc = 0;
    logic [7:0]  got[$];
    int          rd_cyc[$];

    aq_jpeg_hm_bitpack dut (
        .clk           (clk),
        .rst           (rst),
        .ProcessInit   (ProcessInit),
        .CodeInEnable  (CodeInEnable),
        .CodeInReady   (CodeInReady),
        .CodeInData    (CodeInData),
        .CodeInWidth   (CodeInWidth),
        .FlushReq      (FlushReq),
        .FlushDone     (FlushDone),
        .DataOutEnable (DataOutEnable),
        .DataOutData   (DataOutData),
        .DataOutRead   (DataOutRead),
        .Busy          (Busy)
    );

    always #5 clk = ~clk;

    // Byte transfers and FlushDone pulses are observed mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (DataOutEnable && DataOutRead) begin
            got.push_back(DataOutData);
            rd_cyc.push_back(cyc);
        end
        if (FlushDone) begin
            fd_n++;
            fd_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        got.delete();
        rd_cyc.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] w);
        logic ok;
        ok = 1'b0;
        CodeInEnable = 1'b1;
        CodeInData   = d;
        CodeInWidth  = w;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = CodeInReady;
            tick();
        end
        CodeInEnable = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic flush_and_wait(input string tag);
        int fd0;
        fd0 = fd_n;
        FlushReq = 1'b1;
        tick();
        FlushReq = 1'b0;
        for (int i = 0; i < 100 && fd_n == fd0; i++) tick();
        idle(3);
        chk(tag, fd_n - fd0, 32'd1);
    endtask

    initial begin
        int idx;
        int k;
        logic acc_now;
        logic [7:0] exp_b[4];
        logic [5:0] w4[5];

        idle(3);
        rst = 1'b1;
        tick();

        chk("rst_ready", CodeInReady, 1);
        chk("rst_den", DataOutEnable, 0);
        chk("rst_dout", DataOutData, 0);
        chk("rst_fdone", FlushDone, 0);
        chk("rst_busy", Busy, 0);

        // Zero-width code is a no-op; 101 followed by 11111 gives 0xBF.
        DataOutRead = 1'b1;
        clear_log();
        send(32'hFF, 6'd0);
        send(32'h5, 6'd3);
        send(32'hFFFF_FFFF, 6'd5);
        idle(5);
        chk("t1_count", got.size(), 1);
        if (got.size() > 0) chk("t1_byte", got[0], 8'hBF);
        chk("t1_busy", Busy, 0);
        chk("t1_ready", CodeInReady, 1);

        clear_log();
        send(32'hFF, 6'd8);
        idle(5);
        chk("t2_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_ff", got[0], 8'hFF);
            chk("t2_00", got[1], 8'h00);
            chk("t2_gap", rd_cyc[1] - rd_cyc[0], 1);
        end

        clear_log();
        send(32'h0, 6'd1);
        flush_and_wait("t3_fdone_pulse");
        chk("t3_count", got.size(), 1);
        if (got.size() == 1) begin
            chk("t3_byte", got[0], 8'h7F);
            chk("t3_fd_lat", fd_cyc - rd_cyc[0], 1);
        end
        chk("t3_busy", Busy, 0);

        // Back-pressure: one oversize width (treated as 32) in the middle.
        clear_log();
        w4 = '{6'd32, 6'd32, 6'd40, 6'd32, 6'd32};
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        DataOutRead = 1'b0;
        idx = 0;
        k = 0;
        CodeInData = 32'hDEAD_BEEF;
        while (k < 300 && (idx < 5 || got.size() < 20)) begin
            CodeInEnable = (idx < 5);
            CodeInWidth  = (idx < 5) ? w4[idx] : 6'd0;
            DataOutRead  = (k >= 10);
            acc_now = CodeInEnable && CodeInReady;
            if (k == 8) begin
                chk("t4_accepted_held", idx, 2);
                chk("t4_ready_low", CodeInReady, 0);
                chk("t4_den_held", DataOutEnable, 1);
                chk("t4_dout_held", DataOutData, 8'hDE);
            end
            tick();
            if (acc_now) idx++;
            k++;
        end
        CodeInEnable = 1'b0;
        DataOutRead  = 1'b1;
        idle(3);
        chk("t4_count", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            chk($sformatf("t4_byte%0d", i), got[i], exp_b[i % 4]);
        end
        chk("t4_busy", Busy, 0);

        // Padding is not needed when the data ends on a byte boundary.
        clear_log();
        send(32'h7F, 6'd7);
        send(32'h1, 6'd1);
        flush_and_wait("t5_fdone_pulse");
        chk("t5_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t5_ff", got[0], 8'hFF);
            chk("t5_00", got[1], 8'h00);
        end

        send(32'h3, 6'd2);
        chk("t6_busy_before", Busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_ready", CodeInReady, 1);
        chk("t6_async_busy", Busy, 0);
        chk("t6_async_den", DataOutEnable, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        send(32'h3, 6'd2);
        ProcessInit = 1'b1;
        tick();
        ProcessInit = 1'b0;
        chk("t6_pi_ready", CodeInReady, 1);
        chk("t6_pi_busy", Busy, 0);
        chk("t6_pi_den", DataOutEnable, 0);
        chk("t6_pi_fdone", FlushDone, 0);
        clear_log();
        send(32'hA5, 6'd8);
        idle(5);
        chk("t6_count", got.size(), 1);
        if (got.size() == 1) chk("t6_byte", got[0], 8'hA5);
        chk("t6_busy", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
